// File: rtl/tone_generator_if.sv
`timescale 1ns/1ps
// Tone generator port bundle: note request in, square-wave tone and divider status out.
interface tone_generator_if #(
    parameter int unsigned DIV_W = 32
) ();
    logic             enable;
    logic [31:0]      freq_hz;
    logic             tone_out;
    logic             busy;
    logic [DIV_W-1:0] half_period;

    modport master (
        output enable,
        output freq_hz,
        input  tone_out,
        input  busy,
        input  half_period
    );

    modport slave (
        input  enable,
        input  freq_hz,
        output tone_out,
        output busy,
        output half_period
    );
endinterface

// File: rtl/tone_generator.sv
`timescale 1ns/1ps
// Square-wave tone generator: divides CLK_HZ by 2*freq_hz with a restoring divider
// and toggles the output every half_period cycles; new periods land on level boundaries.
module tone_generator #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned DIV_W  = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    tone_generator_if.slave bus
);
    localparam int unsigned FREQ_W = 32;
    localparam int unsigned DVS_W  = FREQ_W + 1;
    localparam int unsigned REM_W  = FREQ_W + 2;
    localparam int unsigned ITER_W = $clog2(DIV_W + 1);

    typedef enum logic [0:0] {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_e;

    div_state_e        state_q, state_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [DIV_W-1:0]  dvd_q, dvd_d;
    logic [DVS_W-1:0]  dvs_q, dvs_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [DIV_W-1:0]  quo_q, quo_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [DIV_W-1:0]  pend_hp_q, pend_hp_d;
    logic              pend_valid_q, pend_valid_d;
    logic [DIV_W-1:0]  hp_q, hp_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              tone_q, tone_d;

    logic [REM_W-1:0]  rem_shift_c;
    logic [REM_W-1:0]  rem_diff_c;
    logic              rem_ge_c;
    logic [DIV_W-1:0]  quo_next_c;
    logic              wrap_c;

    // One restoring-division step: shift in the next dividend bit and trial-subtract
    always_comb begin
        rem_shift_c = (rem_q << 1) | REM_W'(dvd_q[DIV_W-1]);
        rem_ge_c    = rem_shift_c >= REM_W'(dvs_q);
        rem_diff_c  = rem_shift_c - REM_W'(dvs_q);
        quo_next_c  = (quo_q << 1) | DIV_W'(rem_ge_c);
        wrap_c      = bus.enable && (hp_q != '0) && (cnt_q == hp_q - DIV_W'(1));
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= DIV_IDLE;
            freq_q       <= '0;
            dvd_q        <= '0;
            dvs_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            iter_q       <= '0;
            pend_hp_q    <= '0;
            pend_valid_q <= 1'b0;
            hp_q         <= '0;
            cnt_q        <= '0;
            tone_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            freq_q       <= freq_d;
            dvd_q        <= dvd_d;
            dvs_q        <= dvs_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            iter_q       <= iter_d;
            pend_hp_q    <= pend_hp_d;
            pend_valid_q <= pend_valid_d;
            hp_q         <= hp_d;
            cnt_q        <= cnt_d;
            tone_q       <= tone_d;
        end
    end

    // Next state: toggle counter, period adoption, divider, then change detect (highest priority)
    always_comb begin
        state_d      = state_q;
        freq_d       = freq_q;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        iter_d       = iter_q;
        pend_hp_d    = pend_hp_q;
        pend_valid_d = pend_valid_q;
        hp_d         = hp_q;
        cnt_d        = cnt_q;
        tone_d       = tone_q;

        if (!bus.enable) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (hp_q != '0) begin
            if (wrap_c) begin
                cnt_d  = '0;
                tone_d = ~tone_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        // Adopt a new period only where the output cannot glitch
        if (pend_valid_q && ((hp_q == '0) || !bus.enable || wrap_c)) begin
            hp_d         = pend_hp_q;
            pend_valid_d = 1'b0;
            if (hp_q == '0) begin
                cnt_d  = '0;
                tone_d = 1'b0;
            end
        end

        if (state_q == DIV_RUN) begin
            dvd_d  = dvd_q << 1;
            rem_d  = rem_ge_c ? rem_diff_c : rem_shift_c;
            quo_d  = quo_next_c;
            iter_d = iter_q + ITER_W'(1);
            if (iter_q == ITER_W'(DIV_W - 1)) begin
                state_d      = DIV_IDLE;
                pend_hp_d    = (quo_next_c == '0) ? DIV_W'(1) : quo_next_c;
                pend_valid_d = 1'b1;
            end
        end

        if (bus.freq_hz != freq_q) begin
            freq_d = bus.freq_hz;
            if (bus.freq_hz == '0) begin
                state_d      = DIV_IDLE;
                pend_valid_d = 1'b0;
                hp_d         = '0;
                cnt_d        = '0;
                tone_d       = 1'b0;
            end else begin
                state_d = DIV_RUN;
                dvd_d   = DIV_W'(CLK_HZ);
                dvs_d   = {bus.freq_hz, 1'b0};
                rem_d   = '0;
                quo_d   = '0;
                iter_d  = '0;
            end
        end
    end

    assign bus.tone_out    = tone_q;
    assign bus.busy        = (state_q == DIV_RUN);
    assign bus.half_period = hp_q;
endmodule
